// File: rtl/btn_press_decoder.sv
// Button press classifier: short press, long press and auto-repeat
// pulses decoded from a debounced button level.
module btn_press_decoder #(
  parameter int LONG_TICKS   = 3000,
  parameter int REPEAT_TICKS = 600
) (
  input  logic CLK,
  input  logic rst,
  input  logic en,
  input  logic i_btn,
  output logic o_short,
  output logic o_long,
  output logic o_repeat,
  output logic o_held
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  localparam logic [11:0] LONG_LAST = 12'(LONG_TICKS - 1);
  localparam logic [11:0] REP_LAST  = 12'(REPEAT_TICKS - 1);

  state_t      state_q;
  state_t      state_d;
  logic [11:0] cnt_q;
  logic [11:0] cnt_d;
  logic        short_d;
  logic        long_d;
  logic        rep_d;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      o_short  <= 1'b0;
      o_long   <= 1'b0;
      o_repeat <= 1'b0;
      o_held   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      o_short  <= short_d;
      o_long   <= long_d;
      o_repeat <= rep_d;
      o_held   <= (state_d != IDLE);
    end
  end

  // Release is tested before the terminal count so it always wins.
  // A count at or beyond the terminal value is treated as terminal,
  // which keeps cnt bounded even from a corrupted value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && i_btn) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        if (en) begin
          if (!i_btn) begin
            short_d = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q >= LONG_LAST) begin
            long_d  = 1'b1;
            state_d = LONG_HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
      end
      LONG_HELD: begin
        if (en) begin
          if (!i_btn) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q >= REP_LAST) begin
            rep_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_press_decoder.sv
// Bench for btn_press_decoder: vector table, directed corner
// sequences and randomized run against a hold-length model.
module tb_btn_press_decoder;

  localparam int L = 8;
  localparam int R = 3;

  logic CLK = 1'b0;
  logic rst;
  logic en;
  logic i_btn;
  logic o_short;
  logic o_long;
  logic o_repeat;
  logic o_held;

  int checks   = 0;
  int failures = 0;

  btn_press_decoder #(
    .LONG_TICKS  (L),
    .REPEAT_TICKS(R)
  ) dut (
    .CLK     (CLK),
    .rst     (rst),
    .en      (en),
    .i_btn   (i_btn),
    .o_short (o_short),
    .o_long  (o_long),
    .o_repeat(o_repeat),
    .o_held  (o_held)
  );

  always #5 CLK = ~CLK;

  // Model: a press is a run of en-qualified high samples; k counts
  // the samples after the one that started it.
  bit m_press;
  int m_k;
  bit m_s, m_l, m_r, m_h;

  task automatic model_reset();
    m_press = 0; m_k = 0;
    m_s = 0; m_l = 0; m_r = 0; m_h = 0;
  endtask

  task automatic model_edge(input bit b, input bit e);
    m_s = 0; m_l = 0; m_r = 0;
    if (e) begin
      if (b) begin
        if (!m_press) begin
          m_press = 1;
          m_k = 0;
        end else begin
          m_k++;
          if (m_k == L) m_l = 1;
          else if (m_k > L && (m_k - L) % R == 0) m_r = 1;
        end
      end else begin
        if (m_press && m_k < L) m_s = 1;
        m_press = 0;
      end
    end
    m_h = m_press;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic drive(input bit b, input bit e);
    i_btn = b;
    en = e;
    @(posedge CLK);
    model_edge(b, e);
    #1;
  endtask

  task automatic check_model(input string nm);
    chk({nm, ".short"}, o_short, m_s);
    chk({nm, ".long"}, o_long, m_l);
    chk({nm, ".repeat"}, o_repeat, m_r);
    chk({nm, ".held"}, o_held, m_h);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, ".short"}, o_short, 0);
    chk({nm, ".long"}, o_long, 0);
    chk({nm, ".repeat"}, o_repeat, 0);
    chk({nm, ".held"}, o_held, 0);
  endtask

  typedef struct packed {
    logic b, e, s, l, r, h;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int l_at;
    int rq[$];
    bit ps, pl, pr;
    rst = 1'b1;
    en = 1'b0;
    i_btn = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_zero("reset");
    #2 rst = 1'b0;

    // {btn, en, short, long, repeat, held}
    vecs[0]  = 6'b01_0000;
    vecs[1]  = 6'b11_0001;
    vecs[2]  = 6'b11_0001;
    vecs[3]  = 6'b10_0001;
    vecs[4]  = 6'b11_0001;
    vecs[5]  = 6'b11_0001;
    vecs[6]  = 6'b00_0001;
    vecs[7]  = 6'b01_1000;
    vecs[8]  = 6'b01_0000;
    vecs[9]  = 6'b10_0000;
    vecs[10] = 6'b11_0001;
    vecs[11] = 6'b01_1000;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].b, vecs[i].e);
      chk($sformatf("vec%0d.short", i), o_short, vecs[i].s);
      chk($sformatf("vec%0d.long", i), o_long, vecs[i].l);
      chk($sformatf("vec%0d.repeat", i), o_repeat, vecs[i].r);
      chk($sformatf("vec%0d.held", i), o_held, vecs[i].h);
    end
    drive(0, 1);

    // Long hold: 20 high samples, long and repeats at fixed edges
    l_at = -1;
    for (int i = 0; i < 20; i++) begin
      drive(1, 1);
      check_model("hold");
      if (o_long) l_at = i;
      if (o_repeat) rq.push_back(i);
    end
    chk("hold.long_edge", l_at, 8);
    chk("hold.rep_count", rq.size(), 3);
    for (int j = 0; j < rq.size(); j++)
      chk("hold.rep_edge", rq[j], 11 + 3 * j);
    drive(0, 1);
    chk("hold.rel_short", o_short, 0);
    chk("hold.rel_held", o_held, 0);
    drive(0, 1);

    // Release exactly when the count reaches its last value
    for (int i = 0; i < 8; i++) begin
      drive(1, 1);
      check_model("bnd");
    end
    drive(0, 1);
    chk("bnd.short", o_short, 1);
    chk("bnd.long", o_long, 0);
    chk("bnd.held", o_held, 0);
    drive(0, 1);

    // Freeze mid-count
    for (int i = 0; i < 4; i++) drive(1, 1);
    for (int i = 0; i < 50; i++) begin
      drive(1, 0);
      chk("frz.pulses", {o_short, o_long, o_repeat}, 0);
      chk("frz.held", o_held, 1);
    end
    l_at = -1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 1);
      check_model("frz");
      if (o_long && l_at < 0) l_at = i;
    end
    chk("frz.long_edge", l_at, 4);

    // Async reset in LONG_HELD with the button still down
    check_model("pre_rst");
    #3 rst = 1'b1;
    #1 check_zero("async_rst");
    model_reset();
    @(posedge CLK);
    #1 check_zero("rst_hold");
    #2 rst = 1'b0;
    l_at = -1;
    for (int i = 0; i < 12; i++) begin
      drive(1, 1);
      check_model("post_rst");
      if (o_long && l_at < 0) l_at = i;
    end
    chk("post_rst.long_edge", l_at, 8);
    drive(0, 1);
    drive(0, 1);

    // Randomized run
    ps = 0; pl = 0; pr = 0;
    for (int i = 0; i < 10000; i++) begin
      bit b;
      bit e;
      b = ($urandom_range(0, 19) == 0) ? ~i_btn : i_btn;
      e = ($urandom_range(0, 7) != 0);
      drive(b, e);
      check_model("rnd");
      chk("rnd.onehot", $countones({o_short, o_long, o_repeat}) <= 1, 1);
      chk("rnd.width", {ps & o_short, pl & o_long, pr & o_repeat}, 0);
      ps = o_short; pl = o_long; pr = o_repeat;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
